router_fifo: RTL

ROUTER_FIFO -- requirements
Module: router_fifo

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_fifo_mem.sv | 58 +++++
 rtl/router_fifo.sv | 130 +++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared sizing constants and helpers for the router FIFO slice.
//   FIFO_DEPTH : number of entries (16)
//   FIFO_WIDTH : stored bits per entry (8 payload + 1 header marker)
//   ADDR_W     : entry index width
//   PTR_W      : pointer width (index + wrap bit)
//   PKT_CNT_W  : width of the outgoing packet byte counter
// -----------------------------------------------------------------------------
package router_pkg;

   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_WIDTH = 9;
   localparam int ADDR_W     = 4;
   localparam int PTR_W      = ADDR_W + 1;
   localparam int PKT_CNT_W  = 7;

   // A header byte carries the payload length in bits [7:2]; the counter also
   // has to cover the trailing parity byte, hence the +1.
   function automatic logic [PKT_CNT_W-1:0] hdr_pkt_cnt(input logic [7:0] hdr);
      return {1'b0, hdr[7:2]} + 7'd1;
   endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// -----------------------------------------------------------------------------
// router_fifo_mem
// 16 x 9 storage for the router FIFO: one synchronous write port and one
// combinational read port. Payload bits [7:0] live in a plain array with no
// reset; the header marker (bit 8) of every entry is a resettable flop so that
// both resets clear all markers.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset (clears markers)
//   clear      in   synchronous flush (clears markers)
//   wr_en      in   write strobe
//   wr_addr    in   write index
//   wr_data    in   {marker, payload}
//   rd_addr    in   read index
//   rd_data    out  {marker, payload} at rd_addr
// -----------------------------------------------------------------------------
module router_fifo_mem
   import router_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [FIFO_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [FIFO_WIDTH-1:0] rd_data
);

   logic [7:0]            payload_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] marker_reg;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         payload_mem[wr_addr] <= wr_data[7:0];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_marker
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               marker_reg[gi] <= 1'b0;
            end else if (clear) begin
               marker_reg[gi] <= 1'b0;
            end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
               marker_reg[gi] <= wr_data[8];
            end
         end
      end
   endgenerate

   // Only written entries are ever addressed here (the read pointer never
   // passes the write pointer), so the payload is always defined when used.
   assign rd_data = {marker_reg[rd_addr], payload_mem[rd_addr]};

endmodule

// File: rtl/router_fifo.sv
// -----------------------------------------------------------------------------
// router_fifo
// 16-entry byte FIFO for one router output port. Each entry carries a header
// marker captured from lfd_state. When a header is read out, the packet byte
// counter is loaded with payload length + 1 (parity); it counts down on each
// following read. Once the counter is exhausted and nothing is being read,
// data_out returns to 8'h00.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   soft_reset  in   synchronous active-high flush
//   write_enb   in   write request
//   read_enb    in   read request
//   lfd_state   in   current write is a header byte
//   data_in     in   byte to store
//   data_out    out  registered read byte
//   full        out  16 entries occupied
//   empty       out  no entries occupied
//   ovf_err     out  sticky misuse flag (only with ROUTER_FIFO_OVF_FLAG_EN)
// Build option: define ROUTER_FIFO_OVF_FLAG_EN to add ovf_err, which sets on a
// write while full or a read while empty and clears on either reset.
// -----------------------------------------------------------------------------
module router_fifo
   import router_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       soft_reset,
   input  logic       write_enb,
   input  logic       read_enb,
   input  logic       lfd_state,
   input  logic [7:0] data_in,
`ifdef ROUTER_FIFO_OVF_FLAG_EN
   output logic       ovf_err,
`endif
   output logic [7:0] data_out,
   output logic       full,
   output logic       empty
);

   logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
   logic [PKT_CNT_W-1:0]  pkt_cnt_reg, pkt_cnt_next;
   logic [7:0]            data_out_reg, data_out_next;
   logic [FIFO_WIDTH-1:0] rd_data;
   logic                  wr_accept;
   logic                  rd_accept;

   // Same index with opposite wrap bits means the writer is a full lap ahead.
   assign full  = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                  (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);
   assign empty = (wr_ptr_reg == rd_ptr_reg);

   // Acceptance uses the pre-edge flags; a flush suppresses any transfer.
   assign wr_accept = write_enb && !full && !soft_reset;
   assign rd_accept = read_enb && !empty && !soft_reset;

   router_fifo_mem u_mem (
      .clock   (clock),
      .reset   (reset),
      .clear   (soft_reset),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
      .wr_data ({lfd_state, data_in}),
      .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
      .rd_data (rd_data)
   );

   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      pkt_cnt_next  = pkt_cnt_reg;
      data_out_next = data_out_reg;

      if (wr_accept) begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end

      if (rd_accept) begin
         rd_ptr_next   = rd_ptr_reg + PTR_W'(1);
         data_out_next = rd_data[7:0];
         if (rd_data[8]) begin
            pkt_cnt_next = hdr_pkt_cnt(rd_data[7:0]);
         end else if (pkt_cnt_reg != '0) begin
            pkt_cnt_next = pkt_cnt_reg - PKT_CNT_W'(1);
         end
      end else if (pkt_cnt_reg == '0) begin
         // Packet fully delivered: idle the output bus.
         data_out_next = 8'h00;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         pkt_cnt_reg  <= '0;
         data_out_reg <= 8'h00;
      end else if (soft_reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         pkt_cnt_reg  <= '0;
         data_out_reg <= 8'h00;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         pkt_cnt_reg  <= pkt_cnt_next;
         data_out_reg <= data_out_next;
      end
   end

   assign data_out = data_out_reg;

`ifdef ROUTER_FIFO_OVF_FLAG_EN
   logic ovf_err_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ovf_err_reg <= 1'b0;
      end else if (soft_reset) begin
         ovf_err_reg <= 1'b0;
      end else if ((write_enb && full) || (read_enb && empty)) begin
         ovf_err_reg <= 1'b1;
      end
   end

   assign ovf_err = ovf_err_reg;
`endif

endmodule
